// File: rtl/ex_sorter_sorter_valrdy.sv
// Four-element streaming sorter: three compare-and-swap stages with
// val/rdy handshakes on both sides and per-transaction sort direction.
module ex_sorter_sorter_valrdy #(
  parameter int p_nbits  = 8,
  parameter bit p_signed = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic               in_desc,
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic [p_nbits-1:0] in2,
  input  logic [p_nbits-1:0] in3,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out0,
  output logic [p_nbits-1:0] out1,
  output logic [p_nbits-1:0] out2,
  output logic [p_nbits-1:0] out3,
  output logic [1:0]         occupancy
);

  typedef logic [3:0][p_nbits-1:0] quad_t;
  typedef logic [1:0][p_nbits-1:0] pair_t;

  // Result [0] is the new lo slot, [1] the new hi slot.
  // An unknown swap decision poisons both slots.
  function automatic pair_t cas(
    input logic [p_nbits-1:0] lo,
    input logic [p_nbits-1:0] hi,
    input logic               desc
  );
    logic g;
    logic l;
    logic sw;
    if (p_signed) begin
      g = $signed(lo) > $signed(hi);
      l = $signed(lo) < $signed(hi);
    end else begin
      g = lo > hi;
      l = lo < hi;
    end
    sw = desc ? l : g;
    if (sw) begin
      cas = {lo, hi};
    end else if (!sw) begin
      cas = {hi, lo};
    end else begin
      cas = 'x;
    end
  endfunction

  logic  s1_val_q, s1_val_d;
  logic  s2_val_q, s2_val_d;
  logic  s3_val_q, s3_val_d;
  logic  s1_desc_q, s1_desc_d;
  logic  s2_desc_q, s2_desc_d;
  logic  s3_desc_q, s3_desc_d;
  quad_t s1_elm_q, s1_elm_d;
  quad_t s2_elm_q, s2_elm_d;
  quad_t s3_elm_q, s3_elm_d;

  logic  rdy1, rdy2, rdy3;
  pair_t c1a, c1b, c2a, c2b, c3;
  quad_t s1_net, s2_net;

  assign rdy3   = !s3_val_q || out_rdy;
  assign rdy2   = !s2_val_q || rdy3;
  assign rdy1   = !s1_val_q || rdy2;
  assign in_rdy = rdy1 && !reset;

  assign c1a    = cas(s1_elm_q[0], s1_elm_q[1], s1_desc_q);
  assign c1b    = cas(s1_elm_q[2], s1_elm_q[3], s1_desc_q);
  assign s1_net = {c1b[1], c1b[0], c1a[1], c1a[0]};

  assign c2a    = cas(s2_elm_q[0], s2_elm_q[2], s2_desc_q);
  assign c2b    = cas(s2_elm_q[1], s2_elm_q[3], s2_desc_q);
  assign s2_net = {c2b[1], c2a[1], c2b[0], c2a[0]};

  assign c3     = cas(s3_elm_q[1], s3_elm_q[2], s3_desc_q);

  assign out_val = s3_val_q;
  assign out0    = s3_elm_q[0];
  assign out1    = c3[0];
  assign out2    = c3[1];
  assign out3    = s3_elm_q[3];

  assign occupancy = {1'b0, s1_val_q}
                   + {1'b0, s2_val_q}
                   + {1'b0, s3_val_q};

  always_comb begin
    s1_val_d  = s1_val_q;
    s1_desc_d = s1_desc_q;
    s1_elm_d  = s1_elm_q;
    s2_val_d  = s2_val_q;
    s2_desc_d = s2_desc_q;
    s2_elm_d  = s2_elm_q;
    s3_val_d  = s3_val_q;
    s3_desc_d = s3_desc_q;
    s3_elm_d  = s3_elm_q;
    if (rdy1) begin
      s1_val_d  = in_val && in_rdy;
      s1_desc_d = in_desc;
      s1_elm_d  = {in3, in2, in1, in0};
    end
    if (rdy2) begin
      s2_val_d  = s1_val_q;
      s2_desc_d = s1_desc_q;
      s2_elm_d  = s1_net;
    end
    if (rdy3) begin
      s3_val_d  = s2_val_q;
      s3_desc_d = s2_desc_q;
      s3_elm_d  = s2_net;
    end
    if (reset) begin
      s1_val_d = 1'b0;
      s2_val_d = 1'b0;
      s3_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    s1_val_q  <= s1_val_d;
    s2_val_q  <= s2_val_d;
    s3_val_q  <= s3_val_d;
    s1_desc_q <= s1_desc_d;
    s2_desc_q <= s2_desc_d;
    s3_desc_q <= s3_desc_d;
    s1_elm_q  <= s1_elm_d;
    s2_elm_q  <= s2_elm_d;
    s3_elm_q  <= s3_elm_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown({in_val, out_rdy, in_rdy, out_val,
                           s1_val_q, s2_val_q, s3_val_q}))
        else $error("unknown handshake or stage valid");
    end
  end

endmodule
